// File: rtl/elgamal_pkg.sv
// rtl/elgamal_pkg.sv - shared FSM encoding and constants for the ElGamal blocks
package elgamal_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      REQ1,
      WAIT1,
      REQ2,
      WAIT2,
      MUL,
      OUT
   } enc_state_t;

   localparam int MIN_MODULUS = 3;

endpackage

// File: rtl/mod_mult_serial.sv
// rtl/mod_mult_serial.sv - serial MSB-first interleaved modular multiplier, result = a*b mod p
module mod_mult_serial #(
   parameter int SIZE = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic [SIZE-1:0] p,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] result
);

   localparam int CW = $clog2(SIZE + 1);

   logic [SIZE-1:0] r_a;
   logic [SIZE-1:0] r_b;
   logic [SIZE-1:0] r_p;
   logic [SIZE-1:0] r_acc;
   logic [SIZE-1:0] r_result;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_done;

   logic [SIZE:0]   w_dbl;
   logic [SIZE:0]   w_red1;
   logic [SIZE:0]   w_add;
   logic [SIZE-1:0] w_red2;

   // acc stays below p between steps, so SIZE+1 bits cover both 2*acc and acc+a
   always_comb begin
      w_dbl  = {r_acc, 1'b0};
      w_red1 = (w_dbl >= {1'b0, r_p}) ? w_dbl - {1'b0, r_p} : w_dbl;
      w_add  = r_b[SIZE-1] ? w_red1 + {1'b0, r_a} : w_red1;
      w_red2 = (w_add >= {1'b0, r_p}) ? SIZE'(w_add - {1'b0, r_p}) : SIZE'(w_add);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_p      <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_busy) begin
            r_acc <= w_red2;
            r_b   <= r_b << 1;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
               r_result <= w_red2;
            end
         end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_p    <= p;
            r_acc  <= '0;
            r_cnt  <= CW'(SIZE);
            r_busy <= 1'b1;
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: rtl/elgamal_encrypt.sv
// rtl/elgamal_encrypt.sv - ElGamal encryption initiator: c1 = g^k, c2 = m*h^k mod p via an external modexp
module elgamal_encrypt
   import elgamal_pkg::*;
#(
   parameter int SIZE = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] req_p_tdata,
   input  logic [SIZE-1:0] req_g_tdata,
   input  logic [SIZE-1:0] req_h_tdata,
   input  logic [SIZE-1:0] req_k_tdata,
   input  logic [SIZE-1:0] req_m_tdata,
   input  logic            req_tvalid,
   output logic            req_tready,
   output logic [SIZE-1:0] mx_base_tdata,
   output logic [SIZE-1:0] mx_power_tdata,
   output logic [SIZE-1:0] mx_modulus_tdata,
   output logic            mx_tvalid,
   input  logic            mx_base_tready,
   input  logic            mx_power_tready,
   input  logic            mx_modulus_tready,
   input  logic [SIZE-1:0] mx_result_tdata,
   input  logic            mx_result_tvalid,
   output logic            mx_result_tready,
   output logic [SIZE-1:0] out_c1_tdata,
   output logic [SIZE-1:0] out_c2_tdata,
   output logic            out_tuser,
   output logic            out_tvalid,
   input  logic            out_tready
);

   enc_state_t      r_state;
   logic [SIZE-1:0] r_p, r_g, r_h, r_k, r_m;
   logic [SIZE-1:0] r_c1, r_c2;
   logic [SIZE-1:0] r_mx_base, r_mx_power, r_mx_modulus;
   logic            r_req_tready, r_mx_tvalid, r_mx_result_tready;
   logic            r_out_tvalid, r_out_tuser;

   logic            w_req_fire, w_mx_fire, w_res_fire, w_out_fire, w_bad;
   logic            w_mul_start, w_mul_busy, w_mul_done;
   logic [SIZE-1:0] w_mul_result;

   assign w_req_fire = req_tvalid & r_req_tready;
   assign w_mx_fire  = r_mx_tvalid & mx_base_tready & mx_power_tready & mx_modulus_tready;
   assign w_res_fire = mx_result_tvalid & r_mx_result_tready;
   assign w_out_fire = r_out_tvalid & out_tready;
   assign w_bad      = (r_p < SIZE'(MIN_MODULUS)) || (r_k == '0) || (r_m >= r_p)
                       || (r_g >= r_p) || (r_h >= r_p);

   // s is consumed straight off the result bus; the multiplier holds it from here on
   assign w_mul_start = (r_state == WAIT2) && w_res_fire && !w_mul_busy;

   mod_mult_serial #(.SIZE(SIZE)) u_mult (
      .clk    (clk),
      .rst    (rst),
      .start  (w_mul_start),
      .a      (r_m),
      .b      (mx_result_tdata),
      .p      (r_p),
      .busy   (w_mul_busy),
      .done   (w_mul_done),
      .result (w_mul_result)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state            <= IDLE;
         r_p                <= '0;
         r_g                <= '0;
         r_h                <= '0;
         r_k                <= '0;
         r_m                <= '0;
         r_c1               <= '0;
         r_c2               <= '0;
         r_mx_base          <= '0;
         r_mx_power         <= '0;
         r_mx_modulus       <= '0;
         r_req_tready       <= 1'b0;
         r_mx_tvalid        <= 1'b0;
         r_mx_result_tready <= 1'b0;
         r_out_tvalid       <= 1'b0;
         r_out_tuser        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_req_tready <= 1'b1;
               if (w_req_fire) begin
                  r_p          <= req_p_tdata;
                  r_g          <= req_g_tdata;
                  r_h          <= req_h_tdata;
                  r_k          <= req_k_tdata;
                  r_m          <= req_m_tdata;
                  r_req_tready <= 1'b0;
                  r_state      <= CHECK;
               end
            end
            CHECK: begin
               if (w_bad) begin
                  r_c1         <= '0;
                  r_c2         <= '0;
                  r_out_tuser  <= 1'b1;
                  r_out_tvalid <= 1'b1;
                  r_state      <= OUT;
               end else begin
                  r_mx_base    <= r_g;
                  r_mx_power   <= r_k;
                  r_mx_modulus <= r_p;
                  r_mx_tvalid  <= 1'b1;
                  r_state      <= REQ1;
               end
            end
            REQ1, REQ2: begin
               if (w_mx_fire) begin
                  r_mx_tvalid        <= 1'b0;
                  r_mx_result_tready <= 1'b1;
                  r_state            <= (r_state == REQ1) ? WAIT1 : WAIT2;
               end
            end
            WAIT1: begin
               if (w_res_fire) begin
                  r_c1               <= mx_result_tdata;
                  r_mx_result_tready <= 1'b0;
                  r_mx_base          <= r_h;
                  r_mx_tvalid        <= 1'b1;
                  r_state            <= REQ2;
               end
            end
            WAIT2: begin
               if (w_mul_start) begin
                  r_mx_result_tready <= 1'b0;
                  r_state            <= MUL;
               end
            end
            MUL: begin
               if (w_mul_done) begin
                  r_c2         <= w_mul_result;
                  r_out_tvalid <= 1'b1;
                  r_state      <= OUT;
               end
            end
            OUT: begin
               if (w_out_fire) begin
                  r_out_tvalid <= 1'b0;
                  r_out_tuser  <= 1'b0;
                  r_req_tready <= 1'b1;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_tready       = r_req_tready;
   assign mx_base_tdata    = r_mx_base;
   assign mx_power_tdata   = r_mx_power;
   assign mx_modulus_tdata = r_mx_modulus;
   assign mx_tvalid        = r_mx_tvalid;
   assign mx_result_tready = r_mx_result_tready;
   assign out_c1_tdata     = r_c1;
   assign out_c2_tdata     = r_c2;
   assign out_tuser        = r_out_tuser;
   assign out_tvalid       = r_out_tvalid;

endmodule

// File: doc/elgamal_encrypt.md
# elgamal_encrypt

- Initiator side of the modular-exponentiation stream interface.
- Accepts one ElGamal encryption request (message, public key, ephemeral exponent).
- Drives an external `modular_exponentiation` instance twice: c1 = g^k mod p, then s = h^k mod p.
- Computes c2 = m·s mod p in an internal serial modular multiplier and returns (c1, c2) on an output stream.

## Interface
- `SIZE`, 64: operand width in bits for p, g, h, k, m, c1, c2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_p_tdata`, `req_g_tdata`, `req_h_tdata`, `req_k_tdata`, `req_m_tdata`  in  SIZE each  modulus, generator, public key, ephemeral exponent, plaintext.
- `req_tvalid`  in  1  all five request fields valid.
- `req_tready`  out  1  request accepted on `req_tvalid & req_tready`.
- `mx_base_tdata`, `mx_power_tdata`, `mx_modulus_tdata`  out  SIZE each  operands to modexp.
- `mx_tvalid`  out  1  drives all three modexp input tvalids.
- `mx_base_tready`, `mx_power_tready`, `mx_modulus_tready`  in  1 each  modexp input readies; the transfer fires only when all three are high with `mx_tvalid`.
- `mx_result_tdata`  in  SIZE  modexp output.
- `mx_result_tvalid`  in  1  modexp result valid.
- `mx_result_tready`  out  1  result accepted.
- `out_c1_tdata`, `out_c2_tdata`  out  SIZE each  ciphertext.
- `out_tuser`  out  1  error flag: request rejected, c1 = c2 = 0.
- `out_tvalid`  out  1  ciphertext valid.
- `out_tready`  in  1  downstream ready.

## Operation
- **Reset values:** all outputs 0; state IDLE; internal registers 0.
- **FSM states:** IDLE, CHECK, REQ1, WAIT1, REQ2, WAIT2, MUL, OUT.
- **IDLE:**
  - `req_tready` = 1, and only in this state.
  - On handshake, latch all five fields and go to CHECK.
- **CHECK:** one cycle.
  - Error if p < 3, k == 0, m >= p, g >= p or h >= p.
  - On error, set `out_tuser` = 1 and c1 = c2 = 0, then go to OUT.
  - Otherwise go to REQ1.
- **REQ1:**
  - `mx_tvalid` = 1 with base = g, power = k, modulus = p; operands held stable while waiting.
  - On a fired transfer (all three readies high), go to WAIT1.
- **WAIT1:**
  - `mx_result_tready` = 1.
  - On result handshake, c1 ← result, then go to REQ2.
- **REQ2 / WAIT2:** same as REQ1 / WAIT1 with base = h; on result handshake, s ← result.
- **MUL:**
  - Start `mod_mult_serial` with a = m, b = s, p.
  - On its done pulse, c2 ← product, then go to OUT.
- **OUT:**
  - `out_tvalid` = 1; c1, c2 and `out_tuser` held stable until `out_tready`.
  - On handshake, clear `out_tuser` and go to IDLE.
- **Ready/valid gating:**
  - `mx_result_tready` is 0 outside WAIT1/WAIT2; a spurious modexp result is never consumed.
  - `mx_tvalid` is 0 outside REQ1/REQ2.
- **Reset mid-operation:** all valids/readies drop immediately (asynchronous); the FSM returns to IDLE and the in-flight request is discarded.
- **Multiplier arithmetic:** interleaved MSB-first shift-add.
  - Per bit: acc ← 2·acc; if acc ≥ p then acc ← acc − p; if b[i], acc ← acc + a; if acc ≥ p then acc ← acc − p.
  - acc is SIZE+1 bits wide to hold 2·acc and acc + a; inputs satisfy a, b < p, guaranteed by CHECK.

## Timing
- Request accepted in cycle 0; CHECK in cycle 1; `mx_tvalid` asserts in cycle 2.
- `mx_tvalid` may stay high indefinitely under backpressure; no data change while valid.
- MUL lasts SIZE+1 cycles: one load cycle plus one per bit.
- `out_tvalid` asserts on the cycle after done.
- **Total latency:** 2 + (REQ1 wait) + (modexp latency) + 1 + (REQ2 wait) + (modexp latency) + SIZE + 2 cycles.
- **Error path:** `out_tvalid` asserts in cycle 2.
- One request in flight at a time; no pipelining.

## Structure
- **Shared package `elgamal_pkg`:**
  - FSM state enum `enc_state_t`.
  - Localparam `MIN_MODULUS` = 3.
- **Sub-module `mod_mult_serial`, parameter SIZE:**
  - Ports: clk, rst, start, a, b, p, busy, done (1-cycle pulse), result.
  - Reused later by the decryption block.
- The modexp engine is external, not instantiated here.

## Test plan
- **Nominal:** SIZE = 8, behavioural modexp with 5-cycle latency; p = 23, g = 5, h = 8, k = 3, m = 10 → c1 = 10, c2 = 14, `out_tuser` = 0.
- **Multiplier wrap:** p = 251, g = 2, h = 2, k = 1, m = 250 (s = 2) → c1 = 2, c2 = 249. Standalone `mod_mult_serial` check: a = b = 250, p = 251 → 1, done exactly SIZE+1 cycles after start.
- **Error:** m = 23, p = 23 → `out_tvalid` in cycle 2 with `out_tuser` = 1, c1 = c2 = 0, `mx_tvalid` never asserted. Repeat with k = 0 and with p = 2; same response.
- **Backpressure:**
  - Modexp readies held low for 7 cycles → `mx_*_tdata` stable, single transfer counted.
  - `out_tready` low for 10 cycles → outputs stable, exactly one output handshake.
- **Reset mid-operation:** assert `rst` = 0 during WAIT2 → next cycle `mx_result_tready` = 0, `req_tready` = 1 after release. A subsequent nominal request produces the correct ciphertext.
- **Back-to-back:** two requests (nominal, then k = 5, m = 7, giving c1 = 20, c2 = 7·(8^5 mod 23 = 16) mod 23 = 20) → second accepted only after the first output handshake.
